// File: rtl/quad_encoder_counter.sv
// Quadrature encoder position counter with windowed, saturated velocity output.
// Build option: define QUAD_X4_EN for x4 decoding; by default only A rising edges count (x1).
module quad_encoder_counter #(
  parameter int COUNT_W     = 24,
  parameter int VEL_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int VEL_WINDOW  = 500000
) (
  input  logic               CLOCK_50,
  input  logic               Reset,
  input  logic               EncoderReset,
  input  logic               A,
  input  logic               B,
  output logic [COUNT_W-1:0] EncoderCount,
  output logic [VEL_W-1:0]   EncoderVelocity,
  output logic               VelocityValid,
  output logic               EncoderDirection,
  output logic               EncoderError
);

  localparam int WIN_W = $clog2(VEL_WINDOW);
  localparam int EXT_W = (COUNT_W > VEL_W) ? COUNT_W : VEL_W;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(VEL_WINDOW - 1);
  localparam logic signed [EXT_W-1:0] VEL_MAX = {{(EXT_W-VEL_W+1){1'b0}}, {(VEL_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] VEL_MIN = ~VEL_MAX;

  logic [SYNC_STAGES-1:0]  sync_a;
  logic [SYNC_STAGES-1:0]  sync_b;
  logic [1:0]              prev_ab;
  logic [1:0]              cur_ab;
  logic [COUNT_W-1:0]      count;
  logic [COUNT_W-1:0]      snapshot;
  logic [WIN_W-1:0]        win_cnt;
  logic                    step_en;
  logic                    step_up;
  logic                    illegal;
  logic                    win_end;
  logic signed [COUNT_W-1:0] delta;
  logic signed [EXT_W-1:0]   delta_ext;
  logic [VEL_W-1:0]          vel_sat;

  assign cur_ab       = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};
  assign EncoderCount = count;
  assign win_end      = (win_cnt == WIN_LAST);

  // Forward order 00->10->11->01: a single-bit change is forward exactly when new A differs from old B.
  always_comb begin
    illegal = ((cur_ab ^ prev_ab) == 2'b11);
    step_up = cur_ab[1] ^ prev_ab[0];
`ifdef QUAD_X4_EN
    step_en = (cur_ab != prev_ab) && !illegal;
`else
    step_en = !prev_ab[1] && cur_ab[1] && (cur_ab[0] == prev_ab[0]);
`endif
  end

  // Modular difference first, then sign-extend so saturation sees the true signed delta.
  always_comb begin
    delta     = count - snapshot;
    delta_ext = EXT_W'(delta);
    if (delta_ext > VEL_MAX) begin
      vel_sat = {1'b0, {(VEL_W-1){1'b1}}};
    end else if (delta_ext < VEL_MIN) begin
      vel_sat = {1'b1, {(VEL_W-1){1'b0}}};
    end else begin
      vel_sat = VEL_W'(delta_ext);
    end
  end

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      sync_a  <= '0;
      sync_b  <= '0;
      prev_ab <= '0;
    end else begin
      sync_a  <= {sync_a[SYNC_STAGES-2:0], A};
      sync_b  <= {sync_b[SYNC_STAGES-2:0], B};
      prev_ab <= cur_ab;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      count            <= '0;
      snapshot         <= '0;
      win_cnt          <= '0;
      EncoderVelocity  <= '0;
      VelocityValid    <= 1'b0;
      EncoderDirection <= 1'b0;
      EncoderError     <= 1'b0;
    end else if (EncoderReset) begin
      count           <= '0;
      snapshot        <= '0;
      win_cnt         <= '0;
      EncoderVelocity <= '0;
      VelocityValid   <= 1'b0;
      EncoderError    <= 1'b0;
    end else begin
      if (step_en) begin
        count            <= step_up ? count + COUNT_W'(1) : count - COUNT_W'(1);
        EncoderDirection <= step_up;
      end
      if (illegal) begin
        EncoderError <= 1'b1;
      end
      // Snapshot takes the pre-step count, so a step on this cycle lands in the next window.
      if (win_end) begin
        win_cnt         <= '0;
        snapshot        <= count;
        EncoderVelocity <= vel_sat;
        VelocityValid   <= 1'b1;
      end else begin
        win_cnt       <= win_cnt + WIN_W'(1);
        VelocityValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Self-checking bench for quad_encoder_counter; reference model tracks an unbounded position.
module tb_quad_encoder_counter;
  localparam int COUNT_W     = 8;
  localparam int VEL_W       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int VEL_WINDOW  = 100;
`ifdef QUAD_X4_EN
  localparam int SPC = 4;
`else
  localparam int SPC = 1;
`endif
  localparam int MPC = 4 / SPC;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enc_rst = 1'b0;
  logic a = 1'b0;
  logic b = 1'b0;
  logic [COUNT_W-1:0] count;
  logic [VEL_W-1:0]   vel;
  logic valid, dir, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  quad_encoder_counter #(
    .COUNT_W(COUNT_W), .VEL_W(VEL_W), .SYNC_STAGES(SYNC_STAGES), .VEL_WINDOW(VEL_WINDOW)
  ) dut (
    .CLOCK_50(clk), .Reset(rst), .EncoderReset(enc_rst), .A(a), .B(b),
    .EncoderCount(count), .EncoderVelocity(vel), .VelocityValid(valid),
    .EncoderDirection(dir), .EncoderError(err)
  );

  // Reference model
  logic [1:0] hist [0:SYNC_STAGES];
  longint m_pos, m_snap;
  int m_win, m_vel;
  bit m_valid, m_dir, m_err;

  function automatic int ph_idx(input logic [1:0] v);
    case (v)
      2'b00: return 0;
      2'b10: return 1;
      2'b11: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int phase_dist(input logic [1:0] from, input logic [1:0] to);
    return (ph_idx(to) - ph_idx(from) + 4) % 4;
  endfunction

  function automatic int step_of(input logic [1:0] from, input logic [1:0] to);
    int d;
    d = phase_dist(from, to);
`ifdef QUAD_X4_EN
    if (d == 1) return 1;
    if (d == 3) return -1;
    return 0;
`else
    if ((d == 1 || d == 3) && !from[1] && to[1]) return to[0] ? -1 : 1;
    return 0;
`endif
  endfunction

  function automatic int sat_vel(input longint d);
    longint hi;
    hi = (longint'(1) <<< (VEL_W - 1)) - 1;
    if (d > hi) return int'(hi);
    if (d < -hi - 1) return int'(-hi - 1);
    return int'(d);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= SYNC_STAGES; i++) hist[i] <= 2'b00;
      m_pos <= 0; m_snap <= 0; m_win <= 0; m_vel <= 0;
      m_valid <= 1'b0; m_dir <= 1'b0; m_err <= 1'b0;
    end else begin
      hist[0] <= {a, b};
      for (int i = 1; i <= SYNC_STAGES; i++) hist[i] <= hist[i-1];
      if (enc_rst) begin
        m_pos <= 0; m_snap <= 0; m_win <= 0; m_vel <= 0;
        m_valid <= 1'b0; m_err <= 1'b0;
      end else begin
        m_pos <= m_pos + step_of(hist[SYNC_STAGES], hist[SYNC_STAGES-1]);
        if (step_of(hist[SYNC_STAGES], hist[SYNC_STAGES-1]) != 0)
          m_dir <= (step_of(hist[SYNC_STAGES], hist[SYNC_STAGES-1]) > 0);
        if (phase_dist(hist[SYNC_STAGES], hist[SYNC_STAGES-1]) == 2) m_err <= 1'b1;
        if (m_win == VEL_WINDOW - 1) begin
          m_win <= 0; m_snap <= m_pos; m_vel <= sat_vel(m_pos - m_snap); m_valid <= 1'b1;
        end else begin
          m_win <= m_win + 1; m_valid <= 1'b0;
        end
      end
    end
  end

  // Stimulus helpers
  logic [1:0] ph_tab [4];
  int cur_idx = 0;

  task automatic move(input int d, input int hold);
    cur_idx = (cur_idx + d + 4) % 4;
    {a, b} = ph_tab[cur_idx];
    repeat (hold) @(negedge clk);
  endtask

  task automatic enc_pulse();
    enc_rst = 1'b1;
    @(negedge clk);
    enc_rst = 1'b0;
  endtask

  task automatic test_reset();
    a = 1'b0; b = 1'b0; cur_idx = 0; enc_rst = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got=%0h want=0", count); end
    checks++; if (vel !== '0) begin errors++; $display("FAIL reset_vel got=%0h want=0", vel); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", valid); end
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL reset_dir got=%b want=0", dir); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err); end
    rst = 1'b0;
  endtask

  task automatic test_forward_cycle();
    logic [COUNT_W-1:0] exp_c;
    move(1, 2);
    checks++; if (count !== '0) begin errors++; $display("FAIL fwd_latency_hold got=%0d want=0", count); end
    @(negedge clk);
    checks++; if (count !== COUNT_W'(1)) begin errors++; $display("FAIL fwd_latency_step got=%0d want=1", count); end
    repeat (7) @(negedge clk);
    for (int i = 0; i < 3; i++) move(1, 10);
    exp_c = COUNT_W'(SPC);
    checks++; if (count !== exp_c) begin errors++; $display("FAIL fwd_count got=%0d want=%0d", count, exp_c); end
    checks++; if (count !== COUNT_W'(m_pos)) begin errors++; $display("FAIL fwd_model got=%0d want=%0d", count, COUNT_W'(m_pos)); end
    checks++; if (dir !== 1'b1) begin errors++; $display("FAIL fwd_dir got=%b want=1", dir); end
  endtask

  task automatic test_reverse();
    logic [COUNT_W-1:0] exp_c;
    enc_pulse();
    for (int i = 0; i < 12; i++) move(-1, 3);
    repeat (3) @(negedge clk);
    exp_c = COUNT_W'(-3 * SPC);
    checks++; if (count !== exp_c) begin errors++; $display("FAIL rev_count got=%0h want=%0h", count, exp_c); end
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL rev_dir got=%b want=0", dir); end
  endtask

  task automatic test_wrap();
    int n;
    enc_pulse();
    for (int i = 0; i < 127 * MPC; i++) move(1, 1);
    repeat (4) @(negedge clk);
    checks++; if (count !== 8'h7F) begin errors++; $display("FAIL wrap_max got=%0h want=7f", count); end
    n = 0;
    do begin @(negedge clk); n++; end while (!valid && n < 250);
    for (int i = 0; i < MPC; i++) move(1, 1);
    repeat (4) @(negedge clk);
    checks++; if (count !== 8'h80) begin errors++; $display("FAIL wrap_min got=%0h want=80", count); end
    checks++; if (dir !== 1'b1) begin errors++; $display("FAIL wrap_dir got=%b want=1", dir); end
    n = 0;
    do begin @(negedge clk); n++; end while (!valid && n < 250);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL wrap_valid_timeout got=%b want=1", valid); end
    checks++; if ($signed(vel) !== 4'sd1) begin errors++; $display("FAIL wrap_vel got=%0d want=1", $signed(vel)); end
  endtask

  task automatic test_saturation();
    int n;
    enc_pulse();
    n = 0;
    for (int i = 0; i < 20 * MPC; i++) begin move(1, 1); n++; end
    while (!valid && n < 300) begin @(negedge clk); n++; end
    checks++; if (n !== VEL_WINDOW) begin errors++; $display("FAIL sat_timing got=%0d want=%0d", n, VEL_WINDOW); end
    checks++; if (vel !== 4'h7) begin errors++; $display("FAIL sat_vel got=%0d want=7", $signed(vel)); end
    checks++; if (int'($signed(vel)) !== m_vel) begin errors++; $display("FAIL sat_model got=%0d want=%0d", $signed(vel), m_vel); end
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL sat_pulse_width got=%b want=0", valid); end
  endtask

  task automatic test_error_enc_reset();
    logic [COUNT_W-1:0] exp_c;
    bit exp_d;
    while (cur_idx != 0) move(1, 3);
    repeat (4) @(negedge clk);
    exp_c = COUNT_W'(m_pos);
    exp_d = m_dir;
    move(2, 4);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got=%b want=1", err); end
    checks++; if (count !== exp_c) begin errors++; $display("FAIL err_count got=%0h want=%0h", count, exp_c); end
    checks++; if (dir !== exp_d) begin errors++; $display("FAIL err_dir got=%b want=%b", dir, exp_d); end
    move(3, 4);
    move(3, 4);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b want=1", err); end
    move(1, 0);
    repeat (SYNC_STAGES) @(negedge clk);
    enc_rst = 1'b1;
    @(negedge clk);
    enc_rst = 1'b0;
    checks++; if (count !== '0) begin errors++; $display("FAIL encrst_count got=%0h want=0", count); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL encrst_err got=%b want=0", err); end
    repeat (5) @(negedge clk);
    checks++; if (count !== '0) begin errors++; $display("FAIL encrst_no_spurious got=%0h want=0", count); end
  endtask

  task automatic test_async_reset();
    int n;
    enc_pulse();
    for (int i = 0; i < 50 * MPC; i++) move(1, 1);
    repeat (4) @(negedge clk);
    checks++; if (count !== 8'd50) begin errors++; $display("FAIL async_pre_count got=%0d want=50", count); end
    repeat ($urandom_range(10, 40)) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++; if (count !== '0) begin errors++; $display("FAIL async_count got=%0h want=0", count); end
    checks++; if (vel !== '0) begin errors++; $display("FAIL async_vel got=%0h want=0", vel); end
    checks++; if ({valid, dir, err} !== 3'b000) begin errors++; $display("FAIL async_flags got=%b want=000", {valid, dir, err}); end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!valid && n < 300);
    checks++; if (n !== VEL_WINDOW) begin errors++; $display("FAIL async_window got=%0d want=%0d", n, VEL_WINDOW); end
  endtask

  task automatic test_random();
    int r, hold;
    enc_pulse();
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        enc_rst = 1'b1;
      end else begin
        cur_idx = (cur_idx + ((r < 9) ? 2 : ($urandom_range(0, 1) != 0 ? 1 : 3))) % 4;
        {a, b} = ph_tab[cur_idx];
      end
      hold = $urandom_range(1, 3);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        enc_rst = 1'b0;
        checks++; if (count !== COUNT_W'(m_pos)) begin errors++; $display("FAIL rnd_count got=%0h want=%0h", count, COUNT_W'(m_pos)); end
        checks++; if (dir !== m_dir) begin errors++; $display("FAIL rnd_dir got=%b want=%b", dir, m_dir); end
        checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err got=%b want=%b", err, m_err); end
        checks++; if (valid !== m_valid) begin errors++; $display("FAIL rnd_valid got=%b want=%b", valid, m_valid); end
        checks++; if (int'($signed(vel)) !== m_vel) begin errors++; $display("FAIL rnd_vel got=%0d want=%0d", $signed(vel), m_vel); end
      end
    end
  endtask

  initial begin
    ph_tab[0] = 2'b00; ph_tab[1] = 2'b10; ph_tab[2] = 2'b11; ph_tab[3] = 2'b01;
    #2;
    test_reset();
    test_forward_cycle();
    test_reverse();
    test_wrap();
    test_saturation();
    test_error_enc_reset();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/quad_encoder_counter.md
QUAD_ENCODER_COUNTER -- requirements
Module: quad_encoder_counter

Interface
REQ-001 SHALL provide parameter COUNT_W, default 24: width of the signed position count.
REQ-002 SHALL provide parameter VEL_W, default 16: width of the signed velocity output.
REQ-003 SHALL provide parameter SYNC_STAGES, default 2 (legal 2..4): synchronizer depth on A and B.
REQ-004 SHALL provide parameter VEL_WINDOW, default 500000: velocity sample window in clock cycles (10 ms at 50 MHz); legal values are 2 or greater.
REQ-005 Port CLOCK_50, input, 1: the single clock; all state is clocked on its rising edge.
REQ-006 Port Reset, input, 1: asynchronous, active-high reset.
REQ-007 Port EncoderReset, input, 1: synchronous clear of position, velocity and error state.
REQ-008 Ports A and B, input, 1 each: asynchronous quadrature encoder phases.
REQ-009 Port EncoderCount, output, COUNT_W: signed two's-complement position.
REQ-010 Port EncoderVelocity, output, VEL_W: signed position delta over the last window.
REQ-011 Port VelocityValid, output, 1: one-cycle pulse when EncoderVelocity updates.
REQ-012 Port EncoderDirection, output, 1: direction of the last counted step (1 = forward).
REQ-013 Port EncoderError, output, 1: sticky flag for illegal transitions.

Function
REQ-014 A and B SHALL pass through SYNC_STAGES flops; a previous-state register SHALL hold the last synchronized {A,B}.
REQ-015 Forward sequence SHALL be {A,B} = 00->10->11->01->00 (A leads B); the reverse sequence is 00->01->11->10->00.
REQ-016 An input change captured by the first sync flop at edge k SHALL appear on EncoderCount after edge k+SYNC_STAGES.
REQ-017 A transition in which both A and B change SHALL set EncoderError, leave the count and EncoderDirection unchanged, and update the previous-state register.
REQ-018 The count SHALL wrap modulo 2^COUNT_W with no saturation: max+1 -> min, and min-1 -> max.
REQ-019 EncoderDirection SHALL update only on a counted step.
REQ-020 A window counter SHALL run 0..VEL_WINDOW-1; on its terminal cycle:
  - velocity = count - snapshot, saturated to the VEL_W signed range;
  - snapshot <= count;
  - VelocityValid SHALL be high for exactly that one cycle.
REQ-021 For REQ-020, count SHALL be the value before that cycle's step, so a step on the terminal cycle is counted in the next window.
REQ-022 The snapshot subtraction SHALL be done in COUNT_W bits modulo 2^COUNT_W, so deltas across the wrap point are correct.
REQ-023 When EncoderReset is high in a cycle, the following SHALL be cleared to 0 at that edge, overriding any simultaneous step, error or window event:
  - count, snapshot, window counter and velocity;
  - EncoderError and VelocityValid.
REQ-024 EncoderReset SHALL NOT clear the synchronizers or the previous-state register, so no spurious step follows its release.

Reset
REQ-025 Reset SHALL asynchronously clear all sync flops, the previous-state register, count, snapshot, window counter and EncoderVelocity to 0.
REQ-026 Reset SHALL asynchronously clear VelocityValid, EncoderDirection and EncoderError to 0.
REQ-027 Assertion of Reset mid-window SHALL discard the partial window; the first VelocityValid pulse SHALL occur VEL_WINDOW cycles after release.

Configuration
REQ-028 Macro QUAD_X4_EN defined: every legal single-bit transition SHALL count +1 forward or -1 reverse (4 counts per cycle).
REQ-029 QUAD_X4_EN undefined (x1 mode): only synchronized A rising edges SHALL count, +1 if B=0 and -1 if B=1; all other legal transitions SHALL leave the count unchanged.
REQ-030 Error detection per REQ-017 SHALL be identical in both modes.

Verification
REQ-031 X4, SYNC_STAGES=2: one forward cycle 00,10,11,01,00, 10 clocks per state -> EncoderCount=4, EncoderDirection=1; first change visible 2 edges after capture.
REQ-032 X1: 3 reverse cycles -> EncoderCount = -3 (0xFFFFFD at COUNT_W=24), EncoderDirection=0.
REQ-033 X4, COUNT_W=8, count=127, one forward step -> EncoderCount=-128; the next window delta = +1.
REQ-034 VEL_WINDOW=100, VEL_W=4, X4, 20 forward steps inside one window -> EncoderVelocity=7 (saturated), VelocityValid high 1 cycle at cycle 100.
REQ-035 Inputs 00->11 -> EncoderError=1, count unchanged; EncoderReset asserted in the same cycle as a legal step -> count=0, EncoderError=0.
REQ-036 Reset asserted asynchronously mid-window with count=50 -> all outputs 0 immediately; the next VelocityValid comes 100 cycles after release.
